instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Fetch-side initiator for `INSTRUCTION_MEMORY`. It drives the byte-address `pc` into the combinational-read instruction memory and captures each returned 32-bit word with its PC into a small prefetch FIFO. It hands entries to decode over a valid/ready handshake and handles redirects (branch/jump) by flushing the FIFO and restarting at the target. It sits between the instruction memory and the RV32IF decode stage.

## Interface
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `DEPTH`, 2, prefetch FIFO entries; power of 2, ≥2
- `MEM_BYTES`, 100, instruction memory size in bytes (used only under bound check)
- `clk`  in  1  single clock, all logic on posedge
- `reset`  in  1  synchronous, active-high
- `fetch_en`  in  1  global fetch enable; 0 = no new fetches, FIFO still drains
- `imem_pc`  out  32  byte address to instruction memory
- `imem_instr`  in  32  instruction word for `imem_pc`, valid same cycle (combinational read)
- `redirect_valid`  in  1  one-cycle redirect request
- `redirect_pc`  in  32  redirect target; bits [1:0] ignored (treated as 0)
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  decode accepts head
- `out_instr`  out  32  head instruction
- `out_pc`  out  32  head PC
- `fetch_fault`  out  1  sticky out-of-range flag (see Configuration)

## Operation
- State: `fetch_pc` (32b), FIFO storage {pc, instr} × DEPTH, read/write pointers, `count` (0..DEPTH).
- `imem_pc = fetch_pc` combinationally, always.
- pop = `out_valid && out_ready && !redirect_valid`.
- push = `fetch_en && !redirect_valid && (count < DEPTH || pop)` (and in range, if bound check is compiled in). On push, {fetch_pc, imem_instr} is written at the tail, and `fetch_pc <= fetch_pc + 4`. The add wraps modulo 2^32, so 0xFFFF_FFFC goes to 0x0000_0000.
- Simultaneous push and pop when full is legal. `count` is unchanged and pointers advance.
- Redirect has the highest priority. In the same cycle it flushes the FIFO (count, pointers → 0), sets `fetch_pc <= {redirect_pc[31:2], 2'b00}`, and suppresses push and pop. A head presented in the redirect cycle is discarded, not consumed.
- `out_valid = (count != 0)`. When `out_valid = 1`, `out_instr`/`out_pc` come from the head entry. When empty, `out_instr = 32'h0000_0013` (NOP) and `out_pc = 0`.
- Pointers wrap modulo DEPTH. Overflow and underflow are impossible by construction.

## Timing
- Reset (cycle where `reset = 1`):
  - `fetch_pc <= RESET_PC`; count, pointers and `fetch_fault` → 0.
  - No push, because the memory is loading during the same cycle.
  - Outputs while in reset: `out_valid = 0`, `out_instr = 0x13`, `out_pc = 0`, `imem_pc = RESET_PC` from the cycle after reset is first sampled.
- Reset asserted mid-operation discards all entries. It overrides a concurrent redirect.
- Latency:
  - Fetch into an empty FIFO is visible at the output the next cycle (1 cycle).
  - After a redirect, the first target entry is valid 2 cycles after `redirect_valid` is sampled: cycle +1 fetches the target, cycle +2 shows `out_valid`.
- Throughput is 1 instruction/cycle with `out_ready` held high.
- Under backpressure, `fetch_pc` stalls once count = DEPTH. `out_*` hold stable while `out_valid && !out_ready`.
- `fetch_en = 0` freezes `fetch_pc`. Pops continue.

## Configuration
- Macro `FETCH_BOUND_CHECK_EN`.
- Defined:
  - Push also requires `fetch_pc <= MEM_BYTES - 4`.
  - If `fetch_pc > MEM_BYTES - 4` and a push would otherwise occur, `fetch_fault <= 1` (sticky) and `fetch_pc` holds.
  - `fetch_fault` clears only on reset or a redirect. If the redirect target is itself out of range, the flag re-asserts in the following cycle.
  - FIFO entries already held still drain normally.
- Undefined: no range check; `fetch_fault` is tied to 0; `MEM_BYTES` is unused.

## Test plan
- Reset pulse, then idle with `fetch_en = 0` → `out_valid = 0`, `out_instr = 0x00000013`, `out_pc = 0`, `imem_pc = 0`, count stays 0.
- Straight-line fetch with the memory's reset program loaded, `fetch_en = 1`, `out_ready = 1` → out_pc 0x00, 0x04, 0x08, … on consecutive cycles:
  - out_instr 0x404002B7, 0x40000337, 0xF0028053, …
  - first `out_valid` one cycle after reset is released.
- Backpressure: `out_ready = 0` for 5 cycles → count saturates at 2, `imem_pc` holds at 0x08, and out_pc/out_instr hold 0x00/0x404002B7. Releasing `out_ready` delivers 0x00, 0x04, 0x08 with no gaps or duplicates.
- Redirect while full with `redirect_pc = 0x42` → FIFO flushed, the head is not consumed, and `imem_pc = 0x40` next cycle. Two cycles later out_pc = 0x40 and out_instr = 0xA03123D3.
- Simultaneous redirect, `out_ready = 1` and valid head → no pop is counted, and the next output is the target entry. A simultaneous reset and redirect → reset wins, `imem_pc = RESET_PC`.
- With `FETCH_BOUND_CHECK_EN` and MEM_BYTES = 100, straight-line fetch from 0:
  - 0x60 (NOP) is delivered and `fetch_fault` asserts when `fetch_pc = 0x64`.
  - A redirect to 0x00 clears it and fetch resumes.
  - Without the macro, fetch continues past 0x64 and `fetch_fault` stays 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
// Fetch-side initiator for the combinational-read instruction memory. Drives
// fetch_pc onto imem_pc, captures {pc, instr} pairs into a small prefetch FIFO
// and presents the FIFO head to decode. A redirect flushes the FIFO and
// restarts fetching at the word-aligned target.
//
// Optional feature: define FETCH_BOUND_CHECK_EN to stop fetching past
// MEM_BYTES - 4 and raise the sticky fetch_fault flag instead. Without the
// macro there is no range check and fetch_fault is tied low.
//
// Handshake (decode side): an entry transfers on every posedge where
// out_valid && out_ready are both high and redirect_valid is low. out_valid
// never depends on out_ready, and out_pc/out_instr hold stable while
// out_valid && !out_ready. A head presented during a redirect cycle is
// dropped by the flush, not transferred.

module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          DEPTH     = 2,
  parameter int          MEM_BYTES = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fetch_en,
  output logic [31:0] imem_pc,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic        fetch_fault
);

  localparam int          AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);
  localparam logic [AW:0] ONE_COUNT  = (AW + 1)'(1);
  localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

  // Reject configurations the pointer arithmetic cannot support: pointers
  // wrap by overflowing AW bits, so DEPTH must be a power of two.
  generate
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || MEM_BYTES < 4) begin : g_bad_params
      $error("instr_fetch_unit: DEPTH must be a power of 2 >= 2 and MEM_BYTES >= 4");
    end
  endgenerate

  // Architectural state
  logic [31:0]   fetch_pc;
  logic [31:0]   pc_store    [DEPTH];
  logic [31:0]   instr_store [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [AW:0]   count;

  // Per-cycle control
  logic        pop;
  logic        push_req;
  logic        push;
  logic        in_range;
  logic        has_room;
  logic [31:0] redirect_target;

  assign imem_pc         = fetch_pc;
  assign redirect_target = redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_BOUND_CHECK_EN
  localparam logic [31:0] LAST_PC = 32'(MEM_BYTES - 4);
  assign in_range = (fetch_pc <= LAST_PC);
`else
  assign in_range = 1'b1;
`endif

  // Decide pop/push for this cycle; a redirect suppresses both.
  always_comb begin
    pop      = 1'b0;
    push_req = 1'b0;
    push     = 1'b0;
    has_room = (count < FULL_COUNT) || (out_valid && out_ready);
    if (!redirect_valid) begin
      pop      = out_valid && out_ready;
      push_req = fetch_en && has_room;
      push     = push_req && in_range;
    end
  end

  // Fetch address: reset vector, redirect target, or next sequential word.
  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  // FIFO pointers and occupancy; flushed by reset or redirect.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + ONE_COUNT;
        2'b01:   count <= count - ONE_COUNT;
        default: count <= count;
      endcase
    end
  end

  // FIFO storage: capture {fetch_pc, imem_instr} at the tail on push.
  always_ff @(posedge clk) begin
    if (push) begin
      pc_store[wr_ptr]    <= fetch_pc;
      instr_store[wr_ptr] <= imem_instr;
    end
  end

`ifdef FETCH_BOUND_CHECK_EN
  // Sticky out-of-range flag; only reset or a redirect clears it.
  always_ff @(posedge clk) begin
    if (reset || redirect_valid) begin
      fetch_fault <= 1'b0;
    end else if (push_req && !in_range) begin
      fetch_fault <= 1'b1;
    end
  end
`else
  assign fetch_fault = 1'b0;
`endif

  // Head presentation; an empty FIFO shows a NOP at pc 0.
  always_comb begin
    out_valid = (count != '0);
    out_instr = NOP_INSTR;
    out_pc    = 32'h0000_0000;
    if (out_valid) begin
      out_instr = instr_store[rd_ptr];
      out_pc    = pc_store[rd_ptr];
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Testbench for instr_fetch_unit. Models the instruction memory, keeps a
// queue-based reference of the prefetch FIFO and compares the DUT outputs
// after every clock edge. Honours FETCH_BOUND_CHECK_EN the same way the RTL does.

module tb_instr_fetch_unit;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam int          DEPTH     = 2;
  localparam int          MEM_BYTES = 100;

  // Clock / reset and DUT signals
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_en = 1'b0;
  logic [31:0] imem_pc;
  logic [31:0] imem_instr;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_instr;
  logic [31:0] out_pc;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC (RESET_PC),
    .DEPTH    (DEPTH),
    .MEM_BYTES(MEM_BYTES)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .fetch_en      (fetch_en),
    .imem_pc       (imem_pc),
    .imem_instr    (imem_instr),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_instr     (out_instr),
    .out_pc        (out_pc),
    .fetch_fault   (fetch_fault)
  );

  // Instruction memory: reset program words plus random filler
  logic [31:0] mem [0:31];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'(MEM_BYTES)) return mem[a[6:2]];
    return 32'hBEEF_0000 | {16'h0, a[15:0]};
  endfunction

  always_comb imem_instr = mem_word(imem_pc);

  // Reference model: fetch address, FIFO contents as a queue, fault flag
  logic [31:0] model_pc = RESET_PC;
  logic [63:0] model_q[$];
  logic        model_fault = 1'b0;

  // Scoreboard of expected delivered PCs
  logic [31:0] exp_q[$];

  int n_checks = 0;
  int n_pass   = 0;

  wire [97:0] obs = {out_valid, out_pc, out_instr, imem_pc, fetch_fault};

  function automatic logic [97:0] expected_vec();
    logic [63:0] h;
    if (model_q.size() != 0) begin
      h = model_q[0];
      return {1'b1, h[63:32], h[31:0], model_pc, model_fault};
    end
    return {1'b0, 32'h0, 32'h0000_0013, model_pc, model_fault};
  endfunction

  function automatic bit model_in_range(input logic [31:0] a);
`ifdef FETCH_BOUND_CHECK_EN
    return (a <= 32'(MEM_BYTES - 4));
`else
    return (a == a);
`endif
  endfunction

  // Apply one clock of the specification's rules to the model, then clock the DUT.
  task automatic tick();
    bit do_pop;
    if (reset) begin
      model_pc    = RESET_PC;
      model_q.delete();
      model_fault = 1'b0;
    end else if (redirect_valid) begin
      model_q.delete();
      model_pc    = redirect_pc & 32'hFFFF_FFFC;
      model_fault = 1'b0;
    end else begin
      do_pop = (model_q.size() != 0) && out_ready;
      if (do_pop) void'(model_q.pop_front());
      if (fetch_en && model_q.size() < DEPTH) begin
        if (model_in_range(model_pc)) begin
          model_q.push_back({model_pc, mem_word(model_pc)});
          model_pc = model_pc + 32'd4;
        end else begin
          model_fault = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic fen, input logic rdy,
                       input logic rv, input logic [31:0] rpc);
    reset          = rst;
    fetch_en       = fen;
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    tick();
    n_checks++;
    if (obs !== expected_vec()) $display("FAIL reset_vec: got %h expected %h", obs, expected_vec());
    else n_pass++;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== expected_vec()) $display("FAIL idle_vec: got %h expected %h", obs, expected_vec());
      else n_pass++;
    end
    n_checks++;
    if (out_valid !== 1'b0 || out_instr !== 32'h13 || out_pc !== 32'h0 || imem_pc !== 32'h0)
      $display("FAIL idle_outputs: got v=%b i=%h pc=%h ipc=%h expected v=0 i=00000013 pc=0 ipc=0",
               out_valid, out_instr, out_pc, imem_pc);
    else n_pass++;
  endtask

  task automatic test_straight_line();
    logic [31:0] pcs [3];
    logic [31:0] ins [3];
    pcs[0] = 32'h0; pcs[1] = 32'h4; pcs[2] = 32'h8;
    ins[0] = 32'h404002B7; ins[1] = 32'h40000337; ins[2] = 32'hF0028053;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_instr !== ins[i])
        $display("FAIL straight_%0d: got v=%b pc=%h i=%h expected v=1 pc=%h i=%h",
                 i, out_valid, out_pc, out_instr, pcs[i], ins[i]);
      else n_pass++;
      n_checks++;
      if (obs !== expected_vec()) $display("FAIL straight_vec: got %h expected %h", obs, expected_vec());
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      n_checks++;
      if (obs !== expected_vec()) $display("FAIL bp_vec: got %h expected %h", obs, expected_vec());
      else n_pass++;
    end
    n_checks++;
    if (imem_pc !== 32'h8 || out_pc !== 32'h0 || out_instr !== 32'h404002B7 || out_valid !== 1'b1)
      $display("FAIL bp_hold: got ipc=%h pc=%h i=%h v=%b expected ipc=8 pc=0 i=404002b7 v=1",
               imem_pc, out_pc, out_instr, out_valid);
    else n_pass++;
    exp_q.delete();
    exp_q.push_back(32'h0); exp_q.push_back(32'h4); exp_q.push_back(32'h8);
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (!out_valid || exp_q.size() == 0)
        $display("FAIL bp_release_gap: got v=%b expected v=1", out_valid);
      else if (out_pc !== exp_q[0])
        $display("FAIL bp_release_pc: got %h expected %h", out_pc, exp_q[0]);
      else n_pass++;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      tick();
      n_checks++;
      if (obs !== expected_vec()) $display("FAIL bp_release_vec: got %h expected %h", obs, expected_vec());
      else n_pass++;
    end
  endtask

  task automatic test_redirect();
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 1'b0, 32'h0);
    for (int i = 0; i < 3; i++) tick();
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h42);
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || imem_pc !== 32'h40)
      $display("FAIL redirect_flush: got v=%b ipc=%h expected v=0 ipc=00000040", out_valid, imem_pc);
    else n_pass++;
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h40 || out_instr !== 32'hA03123D3)
      $display("FAIL redirect_target: got v=%b pc=%h i=%h expected v=1 pc=00000040 i=a03123d3",
               out_valid, out_pc, out_instr);
    else n_pass++;
    tick();
    n_checks++;
    if (obs !== expected_vec()) $display("FAIL redirect_vec: got %h expected %h", obs, expected_vec());
    else n_pass++;
    // Redirect while a valid head is being accepted: head must be dropped.
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h13);
    tick();
    redirect_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h10 || out_instr !== mem[4])
      $display("FAIL redirect_pop: got v=%b pc=%h i=%h expected v=1 pc=00000010 i=%h",
               out_valid, out_pc, out_instr, mem[4]);
    else n_pass++;
    // Reset and redirect together: reset wins.
    drive(1'b1, 1'b1, 1'b1, 1'b1, 32'h40);
    tick();
    n_checks++;
    if (imem_pc !== RESET_PC || out_valid !== 1'b0)
      $display("FAIL reset_over_redirect: got ipc=%h v=%b expected ipc=%h v=0", imem_pc, out_valid, RESET_PC);
    else n_pass++;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_random();
    logic [31:0] tgt;
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
    tick();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) tgt = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
      else tgt = 32'($urandom_range(0, 127));
      drive($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 8, $urandom_range(0, 9) < 7,
            $urandom_range(0, 11) == 0, tgt);
      tick();
      n_checks++;
      if (obs !== expected_vec()) $display("FAIL random_vec_%0d: got %h expected %h", i, obs, expected_vec());
      else n_pass++;
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  task automatic test_bound();
    bit seen_nop;
    bit reached;
    seen_nop = 1'b0;
    reached  = 1'b0;
    drive(1'b1, 1'b0, 1'b1, 1'b0, 32'h0);
    tick();
    drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
    for (int i = 0; i < 60 && !reached; i++) begin
      tick();
      n_checks++;
      if (obs !== expected_vec()) $display("FAIL bound_vec: got %h expected %h", obs, expected_vec());
      else n_pass++;
      if (out_valid && out_pc == 32'h60 && out_instr == 32'h13) seen_nop = 1'b1;
`ifdef FETCH_BOUND_CHECK_EN
      if (fetch_fault) reached = 1'b1;
`else
      if (imem_pc == 32'h70) reached = 1'b1;
`endif
    end
    n_checks++;
    if (!reached || !seen_nop)
      $display("FAIL bound_reach: got reached=%b nop_seen=%b expected 1/1", reached, seen_nop);
    else n_pass++;
`ifdef FETCH_BOUND_CHECK_EN
    n_checks++;
    if (imem_pc !== 32'h64 || fetch_fault !== 1'b1)
      $display("FAIL bound_fault: got ipc=%h fault=%b expected ipc=00000064 fault=1", imem_pc, fetch_fault);
    else n_pass++;
    drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
    tick();
    redirect_valid = 1'b0;
    n_checks++;
    if (fetch_fault !== 1'b0) $display("FAIL bound_clear: got %b expected 0", fetch_fault);
    else n_pass++;
    tick();
    n_checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0 || fetch_fault !== 1'b0)
      $display("FAIL bound_resume: got v=%b pc=%h fault=%b expected v=1 pc=0 fault=0", out_valid, out_pc, fetch_fault);
    else n_pass++;
`else
    n_checks++;
    if (fetch_fault !== 1'b0 || imem_pc !== 32'h70)
      $display("FAIL bound_nofault: got fault=%b ipc=%h expected fault=0 ipc=00000070", fetch_fault, imem_pc);
    else n_pass++;
`endif
    drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) mem[i] = $urandom;
    mem[0]  = 32'h404002B7;
    mem[1]  = 32'h40000337;
    mem[2]  = 32'hF0028053;
    mem[16] = 32'hA03123D3;
    mem[24] = 32'h0000_0013;
    @(negedge clk);
    test_reset();
    test_straight_line();
    test_backpressure();
    test_redirect();
    test_random();
    test_bound();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
